// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and control bundle for the MIPS pipeline main control.
// Opcodes, ALU/branch classes, FSM state encoding and the ID/EX control struct.
package pipe_ctrl_pkg;

   localparam int OP_RTYPE = 0;
   localparam int OP_J     = 2;
   localparam int OP_BEQ   = 4;
   localparam int OP_BNE   = 5;
   localparam int OP_ADDI  = 8;
   localparam int OP_LW    = 35;
   localparam int OP_SW    = 43;

   localparam logic [1:0] ALU_ADD   = 2'd0;
   localparam logic [1:0] ALU_SUB   = 2'd1;
   localparam logic [1:0] ALU_FUNCT = 2'd2;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BNE  = 2'b01;
   localparam logic [1:0] BR_BEQ  = 2'b11;

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] STALL = 1'b1;

   typedef struct packed {
      logic       reg_dst;
      logic       alu_src;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       reg_write;
      logic       jump;
      logic [1:0] alu_op;
      logic [1:0] branch;
   } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_unit_decode.sv
// Opcode to control-bundle mapping for the ID stage.
// Unknown opcodes decode to an all-zero bubble and raise the illegal flag.
module ctrl_decode
   import pipe_ctrl_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic [OPW-1:0] opcode,
   output ctrl_t          ctrl,
   output logic           illegal,
   output logic           uses_rt
);

   // map opcode to controls; everything unlisted stays zero
   always_comb begin
      ctrl    = '0;
      illegal = 1'b0;
      uses_rt = 1'b0;
      unique case (1'b1)
         (opcode == OPW'(OP_RTYPE)): begin
            ctrl.reg_dst   = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            ctrl.reg_write = 1'b1;
            uses_rt        = 1'b1;
         end
         (opcode == OPW'(OP_BEQ)): begin
            ctrl.branch = BR_BEQ;
            ctrl.alu_op = ALU_SUB;
            uses_rt     = 1'b1;
         end
         (opcode == OPW'(OP_BNE)): begin
            ctrl.branch = BR_BNE;
            ctrl.alu_op = ALU_SUB;
            uses_rt     = 1'b1;
         end
         (opcode == OPW'(OP_LW)): begin
            ctrl.alu_src    = 1'b1;
            ctrl.mem_read   = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
            ctrl.alu_op     = ALU_ADD;
         end
         (opcode == OPW'(OP_SW)): begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
            uses_rt        = 1'b1;
         end
         (opcode == OPW'(OP_ADDI)): begin
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         (opcode == OPW'(OP_J)): begin
            ctrl.jump = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipe_ctrl_hazard_unit.sv
// Main control for the 5-stage pipeline: decode, ID/EX control register,
// load-use stall FSM, flush/hold handling and a saturating bubble counter.
module pipe_ctrl_hazard_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int OPW               = 6,
   parameter int REGW              = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNTW              = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [OPW-1:0]  id_opcode,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic            hold,
   input  logic            flush,
   output logic            pc_write,
   output logic            ifid_write,
   output logic            ifid_flush,
   output logic            ex_reg_dst,
   output logic            ex_alu_src,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_mem_to_reg,
   output logic            ex_reg_write,
   output logic            ex_jump,
   output logic [1:0]      ex_alu_op,
   output logic [1:0]      ex_branch,
   output logic [REGW-1:0] ex_rt,
   output logic            illegal_op,
   output logic [CNTW-1:0] bubble_cnt
);

   ctrl_t      dec;
   logic       dec_illegal;
   logic       uses_rt;
   ctrl_t      ex_q;
   logic [0:0] state;
   logic [2:0] cnt;
   logic       hazard;
   logic       stall;
   logic       bubble;

   ctrl_decode #(.OPW(OPW)) u_decode (
      .opcode  (id_opcode),
      .ctrl    (dec),
      .illegal (dec_illegal),
      .uses_rt (uses_rt)
   );

   assign hazard = (state == RUN) & ex_q.mem_read & (ex_rt != '0)
                 & ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
   assign stall  = hazard | (state == STALL);
   assign bubble = flush | stall | dec_illegal;

   assign pc_write   = ~hold & (flush | ~stall);
   assign ifid_write = ~hold & (flush | ~stall);
   assign ifid_flush = flush & ~hold;

   assign ex_reg_dst    = ex_q.reg_dst;
   assign ex_alu_src    = ex_q.alu_src;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_mem_to_reg = ex_q.mem_to_reg;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_jump       = ex_q.jump;
   assign ex_alu_op     = ex_q.alu_op;
   assign ex_branch     = ex_q.branch;

   // ID/EX register and stall FSM; hold freezes everything but the pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_q       <= '0;
         ex_rt      <= '0;
         illegal_op <= 1'b0;
         state      <= RUN;
         cnt        <= '0;
      end else if (hold) begin
         illegal_op <= 1'b0;
      end else if (flush) begin
         ex_q       <= '0;
         ex_rt      <= '0;
         illegal_op <= 1'b0;
         state      <= RUN;
         cnt        <= '0;
      end else if (stall) begin
         ex_q       <= '0;
         ex_rt      <= '0;
         illegal_op <= 1'b0;
         if (state == RUN) begin
            cnt   <= 3'(LOAD_STALL_CYCLES - 1);
            state <= (LOAD_STALL_CYCLES > 1) ? STALL : RUN;
         end else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= RUN;
         end
      end else begin
         ex_q       <= dec;
         ex_rt      <= id_rt;
         illegal_op <= dec_illegal;
      end
   end

   // count bubbles entering ID/EX, sticking at all-ones
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt <= '0;
      end else if (!hold && bubble && (bubble_cnt != {CNTW{1'b1}})) begin
         bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl_hazard_unit.sv
// Self-checking bench: two DUTs (1 and 2 stall cycles) driven in lockstep,
// directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl_hazard_unit;

   logic       clk;
   logic       rst_n;
   logic [5:0] op;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       hold;
   logic       flush;

   logic       pcw[2], ifw[2], ifl[2];
   logic       rdst[2], asrc[2], mrd[2], mwr[2], m2r[2], rwr[2], jmp[2], ill[2];
   logic [1:0] aop[2], br[2];
   logic [4:0] ert[2];
   logic [15:0] bc_a;
   logic [3:0]  bc_b;

   int checks;
   int failures;

   localparam logic [10:0] E_R    = 11'b1000010_10_00;
   localparam logic [10:0] E_ADDI = 11'b0100010_00_00;

   pipe_ctrl_hazard_unit #(.LOAD_STALL_CYCLES(1), .CNTW(16)) u_a (
      .clk(clk), .rst_n(rst_n), .id_opcode(op), .id_rs(rs), .id_rt(rt),
      .hold(hold), .flush(flush), .pc_write(pcw[0]), .ifid_write(ifw[0]),
      .ifid_flush(ifl[0]), .ex_reg_dst(rdst[0]), .ex_alu_src(asrc[0]),
      .ex_mem_read(mrd[0]), .ex_mem_write(mwr[0]), .ex_mem_to_reg(m2r[0]),
      .ex_reg_write(rwr[0]), .ex_jump(jmp[0]), .ex_alu_op(aop[0]),
      .ex_branch(br[0]), .ex_rt(ert[0]), .illegal_op(ill[0]), .bubble_cnt(bc_a)
   );

   pipe_ctrl_hazard_unit #(.LOAD_STALL_CYCLES(2), .CNTW(4)) u_b (
      .clk(clk), .rst_n(rst_n), .id_opcode(op), .id_rs(rs), .id_rt(rt),
      .hold(hold), .flush(flush), .pc_write(pcw[1]), .ifid_write(ifw[1]),
      .ifid_flush(ifl[1]), .ex_reg_dst(rdst[1]), .ex_alu_src(asrc[1]),
      .ex_mem_read(mrd[1]), .ex_mem_write(mwr[1]), .ex_mem_to_reg(m2r[1]),
      .ex_reg_write(rwr[1]), .ex_jump(jmp[1]), .ex_alu_op(aop[1]),
      .ex_branch(br[1]), .ex_rt(ert[1]), .illegal_op(ill[1]), .bubble_cnt(bc_b)
   );

   always #5 clk = ~clk;

   function automatic logic [10:0] got_ex(int k);
      return {rdst[k], asrc[k], mrd[k], mwr[k], m2r[k], rwr[k], jmp[k], aop[k], br[k]};
   endfunction

   function automatic logic [15:0] bcnt(int k);
      return (k == 0) ? bc_a : {12'd0, bc_b};
   endfunction

   // ---------------- behavioural reference ----------------
   logic [10:0] m_ex[2];
   logic [4:0]  m_rt[2];
   logic        m_ill[2];
   int          m_left[2];
   int          m_cnt[2];
   int          lsc[2]  = '{1, 2};
   int          cmax[2] = '{65535, 15};

   function automatic logic [11:0] dec_ref(logic [5:0] o);
      case (o)
         6'd0:    return {1'b0, E_R};
         6'd4:    return {1'b0, 7'b0, 2'b01, 2'b11};
         6'd5:    return {1'b0, 7'b0, 2'b01, 2'b01};
         6'd35:   return {1'b0, 7'b0110110, 4'b0};
         6'd43:   return {1'b0, 7'b0101000, 4'b0};
         6'd8:    return {1'b0, E_ADDI};
         6'd2:    return {1'b0, 7'b0000001, 4'b0};
         default: return 12'h800;
      endcase
   endfunction

   function automatic bit m_stall(int k);
      bit reads_rt;
      reads_rt = (op == 6'd0) || (op == 6'd4) || (op == 6'd5) || (op == 6'd43);
      if (m_left[k] > 0) return 1'b1;
      return m_ex[k][8] && (m_rt[k] != 0)
             && ((m_rt[k] == rs) || (reads_rt && (m_rt[k] == rt)));
   endfunction

   task automatic m_reset();
      for (int k = 0; k < 2; k++) begin
         m_ex[k] = '0; m_rt[k] = '0; m_ill[k] = 1'b0; m_left[k] = 0; m_cnt[k] = 0;
      end
   endtask

   task automatic m_step(int k);
      logic [11:0] d;
      bit bub;
      bub = 1'b0;
      m_ill[k] = 1'b0;
      if (!hold) begin
         if (flush) begin
            m_ex[k] = '0; m_rt[k] = '0; m_left[k] = 0; bub = 1'b1;
         end else if (m_stall(k)) begin
            if (m_left[k] > 0) m_left[k]--;
            else m_left[k] = lsc[k] - 1;
            m_ex[k] = '0; m_rt[k] = '0; bub = 1'b1;
         end else begin
            d = dec_ref(op);
            m_ex[k] = d[10:0]; m_rt[k] = rt; m_ill[k] = d[11]; bub = d[11];
         end
         if (bub && m_cnt[k] < cmax[k]) m_cnt[k]++;
      end
   endtask

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic issue(logic [5:0] o, logic [4:0] s, logic [4:0] t, logic h, logic f);
      op = o; rs = s; rt = t; hold = h; flush = f;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      op = '0; rs = '0; rt = '0; hold = 1'b0; flush = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b1; op = '0; rs = '0; rt = '0; hold = 1'b0; flush = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({got_ex(k), ert[k], ill[k], bcnt(k)} !== 33'd0) begin
            failures++;
            $display("FAIL reset_regs dut%0d got=%h exp=0", k, {got_ex(k), ert[k], ill[k], bcnt(k)});
         end
         checks++;
         if ({pcw[k], ifw[k], ifl[k]} !== 3'b110) begin
            failures++;
            $display("FAIL reset_comb dut%0d got=%b exp=110", k, {pcw[k], ifw[k], ifl[k]});
         end
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_load_use();
      do_reset();
      issue(6'd35, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      checks++;
      if ({pcw[0], pcw[1], ifw[0], ifw[1]} !== 4'b0000) begin
         failures++; $display("FAIL lu_hazard_pcw got=%b exp=0000", {pcw[0], pcw[1], ifw[0], ifw[1]});
      end
      tick();
      checks++;
      if ({got_ex(0), got_ex(1), bcnt(0), bcnt(1)} !== {22'd0, 16'd1, 16'd1}) begin
         failures++; $display("FAIL lu_bubble got=%h/%h cnt=%0d/%0d exp=0/0 cnt=1/1",
                              got_ex(0), got_ex(1), bcnt(0), bcnt(1));
      end
      checks++;
      if ({pcw[0], pcw[1]} !== 2'b10) begin
         failures++; $display("FAIL lu_second_pcw got=%b exp=10", {pcw[0], pcw[1]});
      end
      tick();
      checks++;
      if (got_ex(0) !== E_R || bcnt(0) !== 16'd1) begin
         failures++; $display("FAIL lu1_issue got=%h cnt=%0d exp=%h cnt=1", got_ex(0), bcnt(0), E_R);
      end
      checks++;
      if (got_ex(1) !== 11'd0 || bcnt(1) !== 16'd2 || pcw[1] !== 1'b1) begin
         failures++; $display("FAIL lu2_second_bubble got=%h cnt=%0d pcw=%b exp=0 cnt=2 pcw=1",
                              got_ex(1), bcnt(1), pcw[1]);
      end
      tick();
      checks++;
      if (got_ex(1) !== E_R || bcnt(1) !== 16'd2) begin
         failures++; $display("FAIL lu2_issue got=%h cnt=%0d exp=%h cnt=2", got_ex(1), bcnt(1), E_R);
      end
   endtask

   task automatic test_no_stall();
      do_reset();
      issue(6'd35, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      checks++;
      if ({pcw[0], pcw[1]} !== 2'b11) begin
         failures++; $display("FAIL ns_r0_pcw got=%b exp=11", {pcw[0], pcw[1]});
      end
      tick();
      issue(6'd35, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      issue(6'd8, 5'd1, 5'd7, 1'b0, 1'b0);
      checks++;
      if ({pcw[0], pcw[1]} !== 2'b11) begin
         failures++; $display("FAIL ns_addi_pcw got=%b exp=11", {pcw[0], pcw[1]});
      end
      tick();
      checks++;
      if (got_ex(0) !== E_ADDI || got_ex(1) !== E_ADDI || ert[0] !== 5'd7 || bcnt(1) !== 16'd0) begin
         failures++; $display("FAIL ns_addi_ex got=%h rt=%0d cnt=%0d exp=%h rt=7 cnt=0",
                              got_ex(0), ert[0], bcnt(1), E_ADDI);
      end
      issue(6'd35, 5'd0, 5'd7, 1'b0, 1'b0);
      tick();
      issue(6'd43, 5'd1, 5'd7, 1'b0, 1'b0);
      checks++;
      if ({pcw[0], pcw[1]} !== 2'b00) begin
         failures++; $display("FAIL ns_sw_rt_pcw got=%b exp=00", {pcw[0], pcw[1]});
      end
   endtask

   task automatic test_flush();
      do_reset();
      issue(6'd35, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b1);
      checks++;
      if ({pcw[0], ifw[0], ifl[0], pcw[1], ifw[1], ifl[1]} !== 6'b111111) begin
         failures++; $display("FAIL fl_comb got=%b exp=111111",
                              {pcw[0], ifw[0], ifl[0], pcw[1], ifw[1], ifl[1]});
      end
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      checks++;
      if (got_ex(0) !== 11'd0 || bcnt(1) !== 16'd1 || {pcw[0], pcw[1]} !== 2'b11) begin
         failures++; $display("FAIL fl_after got=%h cnt=%0d pcw=%b exp=0 cnt=1 pcw=11",
                              got_ex(0), bcnt(1), {pcw[0], pcw[1]});
      end
      tick();
      issue(6'd35, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b1);
      checks++;
      if ({pcw[1], ifl[1]} !== 2'b11) begin
         failures++; $display("FAIL fl_midstall_comb got=%b exp=11", {pcw[1], ifl[1]});
      end
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      checks++;
      if (pcw[1] !== 1'b1 || bcnt(1) !== 16'd3 || got_ex(1) !== 11'd0) begin
         failures++; $display("FAIL fl_midstall_after pcw=%b cnt=%0d ex=%h exp pcw=1 cnt=3 ex=0",
                              pcw[1], bcnt(1), got_ex(1));
      end
      tick();
   endtask

   task automatic test_hold();
      do_reset();
      issue(6'd35, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      tick();
      for (int i = 0; i < 3; i++) begin
         issue(6'd0, 5'd5, 5'd0, 1'b1, 1'b0);
         checks++;
         if ({pcw[0], ifw[0], ifl[0], pcw[1], ifw[1], ifl[1]} !== 6'd0) begin
            failures++; $display("FAIL hold_comb cyc%0d got=%b exp=000000", i,
                                 {pcw[0], ifw[0], ifl[0], pcw[1], ifw[1], ifl[1]});
         end
         tick();
         checks++;
         if (got_ex(1) !== 11'd0 || bcnt(1) !== 16'd1 || bcnt(0) !== 16'd1) begin
            failures++; $display("FAIL hold_frozen cyc%0d ex=%h cnt=%0d/%0d exp ex=0 cnt=1/1",
                                 i, got_ex(1), bcnt(0), bcnt(1));
         end
      end
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      checks++;
      if ({pcw[0], pcw[1]} !== 2'b10) begin
         failures++; $display("FAIL hold_resume_pcw got=%b exp=10", {pcw[0], pcw[1]});
      end
      tick();
      checks++;
      if (bcnt(1) !== 16'd2 || got_ex(0) !== E_R || pcw[1] !== 1'b1) begin
         failures++; $display("FAIL hold_resume cnt=%0d ex0=%h pcw1=%b exp cnt=2 ex0=%h pcw1=1",
                              bcnt(1), got_ex(0), pcw[1], E_R);
      end
      tick();
      checks++;
      if (got_ex(1) !== E_R) begin
         failures++; $display("FAIL hold_issue got=%h exp=%h", got_ex(1), E_R);
      end
   endtask

   task automatic test_illegal_sat();
      do_reset();
      issue(6'd63, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if ({ill[0], ill[1]} !== 2'b11 || got_ex(0) !== 11'd0 || bcnt(0) !== 16'd1) begin
         failures++; $display("FAIL ill_pulse ill=%b ex=%h cnt=%0d exp ill=11 ex=0 cnt=1",
                              {ill[0], ill[1]}, got_ex(0), bcnt(0));
      end
      issue(6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if ({ill[0], ill[1]} !== 2'b00 || got_ex(0) !== E_R) begin
         failures++; $display("FAIL ill_clear ill=%b ex=%h exp ill=00 ex=%h", {ill[0], ill[1]}, got_ex(0), E_R);
      end
      issue(6'd63, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      issue(6'd63, 5'd0, 5'd0, 1'b1, 1'b0);
      tick();
      checks++;
      if (ill[0] !== 1'b0 || bcnt(0) !== 16'd2) begin
         failures++; $display("FAIL ill_hold ill=%b cnt=%0d exp ill=0 cnt=2", ill[0], bcnt(0));
      end
      for (int i = 0; i < 16; i++) begin
         issue(6'd63, 5'd0, 5'd0, 1'b0, 1'b0);
         tick();
      end
      checks++;
      if (bcnt(0) !== 16'd18 || bcnt(1) !== 16'd15) begin
         failures++; $display("FAIL sat_reach cnt=%0d/%0d exp 18/15", bcnt(0), bcnt(1));
      end
      issue(6'd63, 5'd0, 5'd0, 1'b0, 1'b0);
      tick();
      checks++;
      if (bcnt(0) !== 16'd19 || bcnt(1) !== 16'd15) begin
         failures++; $display("FAIL sat_hold cnt=%0d/%0d exp 19/15", bcnt(0), bcnt(1));
      end
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      issue(6'd35, 5'd0, 5'd5, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      tick();
      issue(6'd0, 5'd5, 5'd0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({got_ex(1), ert[1], ill[1], bcnt(1)} !== 33'd0 || pcw[1] !== 1'b1) begin
         failures++; $display("FAIL rst_mid regs=%h pcw=%b exp regs=0 pcw=1",
                              {got_ex(1), ert[1], ill[1], bcnt(1)}, pcw[1]);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (got_ex(1) !== E_R || bcnt(1) !== 16'd0) begin
         failures++; $display("FAIL rst_mid_after ex=%h cnt=%0d exp ex=%h cnt=0", got_ex(1), bcnt(1), E_R);
      end
   endtask

   task automatic test_random();
      logic [5:0] ops[10] = '{6'd0, 6'd2, 6'd4, 6'd5, 6'd8, 6'd35, 6'd43, 6'd63, 6'd1, 6'd12};
      logic [2:0] ce, cg;
      do_reset();
      m_reset();
      for (int i = 0; i < 600; i++) begin
         issue(ops[$urandom_range(0, 9)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
         for (int k = 0; k < 2; k++) begin
            ce[2] = !hold && (flush || !m_stall(k));
            ce[1] = ce[2];
            ce[0] = flush && !hold;
            cg = {pcw[k], ifw[k], ifl[k]};
            checks++;
            if (cg !== ce) begin
               failures++; $display("FAIL rnd_comb i=%0d dut%0d got=%b exp=%b", i, k, cg, ce);
            end
         end
         if ($urandom_range(0, 59) == 0) begin
            rst_n = 1'b0;
            #1 rst_n = 1'b1;
            m_reset();
         end
         tick();
         for (int k = 0; k < 2; k++) m_step(k);
         for (int k = 0; k < 2; k++) begin
            checks++;
            if ({got_ex(k), ert[k], ill[k], bcnt(k)} !== {m_ex[k], m_rt[k], m_ill[k], 16'(m_cnt[k])}) begin
               failures++; $display("FAIL rnd_regs i=%0d dut%0d got=%h exp=%h", i, k,
                                    {got_ex(k), ert[k], ill[k], bcnt(k)},
                                    {m_ex[k], m_rt[k], m_ill[k], 16'(m_cnt[k])});
            end
         end
      end
   endtask

   initial begin
      clk = 1'b0;
      checks = 0;
      failures = 0;
      test_reset();
      test_load_use();
      test_no_stall();
      test_flush();
      test_hold();
      test_illegal_sat();
      test_reset_mid_stall();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl_hazard_unit.md
Name: pipe_ctrl_hazard_unit

Overview:
- Next-generation main control for the 5-stage MIPS pipeline.
- Decodes the IF/ID opcode and owns the registered ID/EX control bundle.
- Detects load-use hazards itself and inserts a parametrised number of bubbles.
- Squashes on branch flush, freezes on external hold, flags illegal opcodes, and counts inserted bubbles.

Parameters:
- OPW, 6, opcode width.
- REGW, 5, register-index width.
- LOAD_STALL_CYCLES, 1, bubbles per load-use hazard (1 = with forwarding, 2 = without); legal range 1..7.
- CNTW, 16, width of the bubble performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_opcode  in  OPW  opcode of the instruction in ID.
- id_rs  in  REGW  rs field of the ID instruction.
- id_rt  in  REGW  rt field of the ID instruction.
- hold  in  1  global freeze (memory wait).
- flush  in  1  branch taken; squash the ID instruction.
- pc_write  out  1  PC update enable (combinational).
- ifid_write  out  1  IF/ID register enable (combinational).
- ifid_flush  out  1  clear IF/ID (combinational, equals flush & ~hold).
- ex_reg_dst, ex_alu_src, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_reg_write, ex_jump  out  1 each  registered ID/EX controls.
- ex_alu_op  out  2  registered ALU operation class.
- ex_branch  out  2  registered branch kind.
- ex_rt  out  REGW  registered rt (load destination used for hazard compare).
- illegal_op  out  1  registered one-cycle pulse.
- bubble_cnt  out  CNTW  saturating count of bubbles inserted.

Behaviour:
- Reset: asynchronous and active-low. All registered outputs, the state, the stall counter and bubble_cnt go to 0. State resets to RUN.
- Decode (combinational, no X; all unlisted fields are 0):
  - 0 (R-type): reg_dst=1, alu_op=2, reg_write=1.
  - 4 (BEQ): branch=2'b11, alu_op=1.
  - 5 (BNE): branch=2'b01, alu_op=1.
  - 35 (LW): alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1, alu_op=0.
  - 43 (SW): alu_src=1, mem_write=1.
  - 8 (ADDI): alu_src=1, reg_write=1.
  - 2 (J): jump=1.
  - Any other opcode: illegal; decodes to a bubble (all 0).
- uses_rt is 1 for R-type, BEQ, BNE and SW.
- hazard = state==RUN & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)).
- stall = hazard | state==STALL.
- Priority order: rst_n > hold > flush > stall > normal.
- hold=1:
  - All registers keep their value; illegal_op goes to 0.
  - pc_write=0, ifid_write=0, ifid_flush=0.
- flush=1 (hold=0):
  - ID/EX loads a bubble; state goes to RUN and the counter clears.
  - pc_write=1, ifid_write=1, ifid_flush=1.
  - illegal_op is not raised for the squashed opcode.
- stall (hold=0, flush=0):
  - ID/EX loads a bubble; pc_write=0, ifid_write=0.
  - In RUN on hazard: cnt <= LOAD_STALL_CYCLES-1. Next state is STALL if LOAD_STALL_CYCLES>1, otherwise RUN.
  - In STALL: cnt <= cnt-1; when cnt==1 the next state is RUN.
  - Total stalled cycles per hazard = LOAD_STALL_CYCLES. The ID instruction is then issued on the following edge.
- Normal: ID/EX loads the decoded controls and ex_rt <= id_rt. pc_write=1, ifid_write=1. illegal_op <= decode-illegal.
- bubble_cnt increments by 1 on every non-hold edge where ID/EX loads a bubble (flush, stall or illegal). It saturates at all-ones and never wraps.
- Latency: opcode to ex_* is one clock edge.
- Reset asserted mid-stall: takes effect immediately. After release, state is RUN and no residual stall remains.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - opcode constants (OP_RTYPE=0, OP_J=2, OP_BEQ=4, OP_BNE=5, OP_ADDI=8, OP_LW=35, OP_SW=43);
  - ALU-op constants (ALU_ADD=0, ALU_SUB=1, ALU_FUNCT=2);
  - branch constants (BR_NONE=0, BR_BNE=1, BR_BEQ=3);
  - state encoding (RUN, STALL).
- One sub-module, ctrl_decode: a purely combinational opcode-to-control mapping with an illegal flag. The top level keeps the FSM, the ID/EX registers and the counter.

Test Plan:
- Reset, then LW (35) with rt=5 followed by ADD (0) with rs=5 and LOAD_STALL_CYCLES=1 -> exactly 1 cycle with pc_write=0; ex_* all 0 for that cycle; then ex_reg_dst=1, ex_alu_op=2; bubble_cnt=1.
- Same sequence with LOAD_STALL_CYCLES=2 -> 2 stall cycles, 2 bubbles, bubble_cnt=2.
- LW with rt=0 followed by a use of r0 -> no stall; LW rt=7 followed by ADDI using rt=7 only -> no stall, because ADDI does not read rt.
- flush=1 on the first stall cycle of a hazard -> ifid_flush=1, pc_write=1, ID/EX bubble, state RUN, no further stall.
- hold=1 for 3 cycles during a STALL -> ex_* and the counter are frozen, pc_write=0; the stall resumes with the correct remaining count after release.
- Opcode 63 -> illegal_op pulses 1 for one cycle and ex_* are all 0. Forcing bubble_cnt to all-ones then injecting another bubble leaves it at all-ones. Asserting rst_n=0 mid-stall clears all outputs immediately.
